// File: rtl/reg_wr_arbiter_pkg.sv
// ============================================================================
// reg_arb_pkg: shared constants and FSM state type for reg_wr_arbiter.
// Revision 1.0
// ============================================================================
`default_nettype none

package reg_arb_pkg;

   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_RAM_DEPTH   = 256;
   localparam int STATS_CNT_WIDTH = 16;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/reg_wr_arbiter_if.sv
// ============================================================================
// reg_wr_arbiter_if: writer-side request bus plus RAM write-port handshake.
// Revision 1.0
// ============================================================================
`default_nettype none

interface reg_wr_arbiter_if
   import reg_arb_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int RAM_DEPTH  = DEF_RAM_DEPTH,
   parameter int NUM_REQ    = 2
);
   localparam int LB_RAM_DEPTH = $clog2(RAM_DEPTH);
   localparam int IW           = $clog2(NUM_REQ);

   logic [NUM_REQ*DATA_WIDTH-1:0]   req_data;
   logic [NUM_REQ*LB_RAM_DEPTH-1:0] req_addr;
   logic [NUM_REQ-1:0]              req_valid;
   logic [NUM_REQ-1:0]              req_ready;
   logic [DATA_WIDTH-1:0]           mem_data;
   logic [LB_RAM_DEPTH-1:0]         mem_addr;
   logic                            mem_valid;
   logic                            mem_ready;
   logic [IW-1:0]                   grant_id;
   logic                            busy;

   modport master (
      output req_data, req_addr, req_valid, mem_ready,
      input  req_ready, mem_data, mem_addr, mem_valid, grant_id, busy
   );

   modport slave (
      input  req_data, req_addr, req_valid, mem_ready,
      output req_ready, mem_data, mem_addr, mem_valid, grant_id, busy
   );

endinterface

`default_nettype wire

// File: rtl/reg_wr_arbiter_rr_select.sv
// ============================================================================
// reg_rr_select: combinational round-robin pick, searching from last+1.
// Revision 1.0
// ============================================================================
`default_nettype none

module reg_rr_select #(
   parameter int NUM_REQ = 2,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IW-1:0]      last,
   output logic [NUM_REQ-1:0] grant_oh,
   output logic [IW-1:0]      grant_idx,
   output logic               any_valid
);

   logic [IW-1:0] w_cand;

   // Offsets 1..NUM_REQ visit every requester once, ending on last itself.
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      any_valid = 1'b0;
      w_cand    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = IW'((int'(last) + k) % NUM_REQ);
         if (!any_valid && valid[w_cand]) begin
            any_valid        = 1'b1;
            grant_idx        = w_cand;
            grant_oh[w_cand] = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/reg_wr_arbiter.sv
// ============================================================================
// reg_wr_arbiter: round-robin arbiter for the register RAM write port.
// REG_WR_ARB_STATS_EN adds per-requester saturating grant counters. Rev 1.0
// ============================================================================
`default_nettype none

module reg_wr_arbiter
   import reg_arb_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int RAM_DEPTH  = DEF_RAM_DEPTH,
   parameter int NUM_REQ    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef REG_WR_ARB_STATS_EN
   output logic [NUM_REQ*STATS_CNT_WIDTH-1:0] grant_cnt,
`endif
   reg_wr_arbiter_if.slave       bus
);

   localparam int LB_RAM_DEPTH = $clog2(RAM_DEPTH);
   localparam int IW           = $clog2(NUM_REQ);

   state_t                  r_state, w_state_nxt;
   logic [IW-1:0]           r_last, w_last_nxt;
   logic [DATA_WIDTH-1:0]   r_mem_data, w_mem_data_nxt;
   logic [LB_RAM_DEPTH-1:0] r_mem_addr, w_mem_addr_nxt;
   logic                    r_mem_valid, w_mem_valid_nxt;
   logic [IW-1:0]           r_grant_id, w_grant_id_nxt;
   logic [NUM_REQ-1:0]      r_req_ready, w_req_ready_nxt;

   logic [NUM_REQ-1:0]      w_sel_oh;
   logic [IW-1:0]           w_sel_idx;
   logic                    w_any_valid;

   reg_rr_select #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_select (
      .valid     (bus.req_valid),
      .last      (r_last),
      .grant_oh  (w_sel_oh),
      .grant_idx (w_sel_idx),
      .any_valid (w_any_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_last      <= IW'(NUM_REQ - 1);
         r_mem_data  <= '0;
         r_mem_addr  <= '0;
         r_mem_valid <= 1'b0;
         r_grant_id  <= '0;
         r_req_ready <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_last      <= w_last_nxt;
         r_mem_data  <= w_mem_data_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_valid <= w_mem_valid_nxt;
         r_grant_id  <= w_grant_id_nxt;
         r_req_ready <= w_req_ready_nxt;
      end
   end

   // Accept pulse is only ever set on the IDLE->ISSUE edge, so it lasts one cycle.
   always_comb begin
      w_state_nxt     = r_state;
      w_last_nxt      = r_last;
      w_mem_data_nxt  = r_mem_data;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_valid_nxt = r_mem_valid;
      w_grant_id_nxt  = r_grant_id;
      w_req_ready_nxt = '0;
      case (r_state)
         IDLE: begin
            if (w_any_valid) begin
               w_mem_data_nxt  = bus.req_data[int'(w_sel_idx)*DATA_WIDTH +: DATA_WIDTH];
               w_mem_addr_nxt  = bus.req_addr[int'(w_sel_idx)*LB_RAM_DEPTH +: LB_RAM_DEPTH];
               w_grant_id_nxt  = w_sel_idx;
               w_last_nxt      = w_sel_idx;
               w_mem_valid_nxt = 1'b1;
               w_req_ready_nxt = w_sel_oh;
               w_state_nxt     = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.mem_ready) begin
               w_mem_valid_nxt = 1'b0;
               w_state_nxt     = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign bus.req_ready = r_req_ready;
   assign bus.mem_data  = r_mem_data;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_valid = r_mem_valid;
   assign bus.grant_id  = r_grant_id;
   assign bus.busy      = (r_state == ISSUE);

`ifdef REG_WR_ARB_STATS_EN
   logic w_xfer;
   assign w_xfer = r_mem_valid && bus.mem_ready;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      logic [STATS_CNT_WIDTH-1:0] r_cnt;
      always_ff @(posedge clk) begin
         if (rst) begin
            r_cnt <= '0;
         end else if (w_xfer && (r_grant_id == IW'(gi)) && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
      assign grant_cnt[gi*STATS_CNT_WIDTH +: STATS_CNT_WIDTH] = r_cnt;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_wr_arbiter.sv
// ============================================================================
// tb_reg_wr_arbiter: directed vector table plus multi-cycle corner sequences.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_reg_wr_arbiter;

   localparam int DW = 32;
   localparam int NR = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   reg_wr_arbiter_if #(.DATA_WIDTH(DW), .RAM_DEPTH(256), .NUM_REQ(NR)) bus ();

`ifdef REG_WR_ARB_STATS_EN
   logic [NR*16-1:0] grant_cnt;
   reg_wr_arbiter #(.DATA_WIDTH(DW), .RAM_DEPTH(256), .NUM_REQ(NR)) dut (
      .clk(clk), .rst(rst), .grant_cnt(grant_cnt), .bus(bus));
`else
   reg_wr_arbiter #(.DATA_WIDTH(DW), .RAM_DEPTH(256), .NUM_REQ(NR)) dut (
      .clk(clk), .rst(rst), .bus(bus));
`endif

   typedef struct {
      logic [1:0]  valid;
      logic [31:0] d0;
      logic [7:0]  a0;
      logic [31:0] d1;
      logic [7:0]  a1;
      logic        mr;
      logic [1:0]  e_ready;
      logic        e_mv;
      logic [7:0]  e_addr;
      logic [31:0] e_data;
      logic        e_gid;
      logic        e_busy;
   } vec_t;

   vec_t vt [14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [31:0] d0, input logic [7:0] a0,
                        input logic [31:0] d1, input logic [7:0] a1, input logic mr);
      bus.req_valid = v;
      bus.req_data  = {d1, d0};
      bus.req_addr  = {a1, a0};
      bus.mem_ready = mr;
   endtask

   initial begin
      logic [31:0] cd0, cd1;
      logic        exp_g;
      int          grants, n0, n1;

      //          valid  d0            a0     d1            a1     mr    rdy    mv    addr   data          gid   busy
      vt[0]  = '{2'b11, 32'h12121212, 8'h7F, 32'h12345678, 8'hFF, 1'b1, 2'b01, 1'b1, 8'h7F, 32'h12121212, 1'b0, 1'b1};
      vt[1]  = '{2'b10, 32'h12121212, 8'h7F, 32'h12345678, 8'hFF, 1'b1, 2'b00, 1'b0, 8'h7F, 32'h12121212, 1'b0, 1'b0};
      vt[2]  = '{2'b10, 32'h12121212, 8'h7F, 32'h12345678, 8'hFF, 1'b1, 2'b10, 1'b1, 8'hFF, 32'h12345678, 1'b1, 1'b1};
      vt[3]  = '{2'b00, 32'h12121212, 8'h7F, 32'h12345678, 8'hFF, 1'b1, 2'b00, 1'b0, 8'hFF, 32'h12345678, 1'b1, 1'b0};
      vt[4]  = '{2'b01, 32'h12345678, 8'hFF, 32'h00000000, 8'h00, 1'b1, 2'b01, 1'b1, 8'hFF, 32'h12345678, 1'b0, 1'b1};
      vt[5]  = '{2'b00, 32'h12345678, 8'hFF, 32'h00000000, 8'h00, 1'b1, 2'b00, 1'b0, 8'hFF, 32'h12345678, 1'b0, 1'b0};
      vt[6]  = '{2'b00, 32'h12345678, 8'hFF, 32'h00000000, 8'h00, 1'b0, 2'b00, 1'b0, 8'hFF, 32'h12345678, 1'b0, 1'b0};
      vt[7]  = '{2'b10, 32'h00000000, 8'h00, 32'hAAAA5555, 8'h10, 1'b0, 2'b10, 1'b1, 8'h10, 32'hAAAA5555, 1'b1, 1'b1};
      vt[8]  = '{2'b00, 32'h00000000, 8'h00, 32'hAAAA5555, 8'h10, 1'b0, 2'b00, 1'b1, 8'h10, 32'hAAAA5555, 1'b1, 1'b1};
      vt[9]  = '{2'b00, 32'h00000000, 8'h00, 32'hAAAA5555, 8'h10, 1'b1, 2'b00, 1'b0, 8'h10, 32'hAAAA5555, 1'b1, 1'b0};
      vt[10] = '{2'b11, 32'h00000001, 8'h01, 32'h00000002, 8'h02, 1'b1, 2'b01, 1'b1, 8'h01, 32'h00000001, 1'b0, 1'b1};
      vt[11] = '{2'b10, 32'h00000001, 8'h01, 32'h00000002, 8'h02, 1'b1, 2'b00, 1'b0, 8'h01, 32'h00000001, 1'b0, 1'b0};
      vt[12] = '{2'b10, 32'h00000001, 8'h01, 32'h00000002, 8'h02, 1'b1, 2'b10, 1'b1, 8'h02, 32'h00000002, 1'b1, 1'b1};
      vt[13] = '{2'b00, 32'h00000001, 8'h01, 32'h00000002, 8'h02, 1'b1, 2'b00, 1'b0, 8'h02, 32'h00000002, 1'b1, 1'b0};

      // Long reset with random requests: everything must stay at zero.
      rst = 1'b1;
      drive(2'b00, 32'h0, 8'h0, 32'h0, 8'h0, 1'b1);
      for (int c = 0; c < 100; c++) begin
         bus.req_valid = 2'($urandom_range(0, 3));
         step();
         chk("reset outputs", {bus.req_ready, bus.mem_valid, bus.mem_addr, bus.mem_data,
                               bus.grant_id, bus.busy}, 64'd0);
      end
`ifdef REG_WR_ARB_STATS_EN
      chk("reset grant_cnt", 64'(grant_cnt), 64'd0);
`endif
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         drive(vt[i].valid, vt[i].d0, vt[i].a0, vt[i].d1, vt[i].a1, vt[i].mr);
         step();
         chk($sformatf("v%0d req_ready", i), 64'(bus.req_ready), 64'(vt[i].e_ready));
         chk($sformatf("v%0d mem_valid", i), 64'(bus.mem_valid), 64'(vt[i].e_mv));
         chk($sformatf("v%0d mem_addr", i),  64'(bus.mem_addr),  64'(vt[i].e_addr));
         chk($sformatf("v%0d mem_data", i),  64'(bus.mem_data),  64'(vt[i].e_data));
         chk($sformatf("v%0d grant_id", i),  64'(bus.grant_id),  64'(vt[i].e_gid));
         chk($sformatf("v%0d busy", i),      64'(bus.busy),      64'(vt[i].e_busy));
      end

      // Backpressure: ten stalled cycles, requester 1 waiting throughout.
      drive(2'b01, 32'hDEADBEEF, 8'h33, 32'hCAFEF00D, 8'h44, 1'b0);
      step();
      chk("bp accept", 64'(bus.req_ready), 64'b01);
      bus.req_valid = 2'b10;
      for (int c = 0; c < 10; c++) begin
         step();
         chk("bp hold", {bus.req_ready, bus.mem_valid, bus.mem_addr, bus.mem_data, bus.busy},
             {2'b00, 1'b1, 8'h33, 32'hDEADBEEF, 1'b1});
      end
      bus.mem_ready = 1'b1;
      step();
      chk("bp complete", {bus.req_ready, bus.mem_valid, bus.busy}, {2'b00, 1'b0, 1'b0});
      step();
      chk("bp next grant", {bus.req_ready, bus.grant_id, bus.mem_addr, bus.mem_data},
          {2'b10, 1'b1, 8'h44, 32'hCAFEF00D});
      bus.req_valid = 2'b00;
      step();

      // Continuous contention after a fresh reset: strict 0,1,0,1 rotation.
      rst = 1'b1;
      step();
      rst = 1'b0;
      cd0 = 32'h0A000000;
      cd1 = 32'h0B000000;
      drive(2'b11, cd0, 8'h20, cd1, 8'h21, 1'b1);
      exp_g  = 1'b0;
      grants = 0;
      n0 = 0;
      n1 = 0;
      for (int c = 0; c < 100 && grants < 20; c++) begin
         step();
         if (bus.req_ready != 2'b00) begin
            chk("cont ready", 64'(bus.req_ready), exp_g ? 64'b10 : 64'b01);
            chk("cont grant_id", 64'(bus.grant_id), 64'(exp_g));
            chk("cont mem_data", 64'(bus.mem_data), exp_g ? 64'(cd1) : 64'(cd0));
            if (bus.req_ready[0]) begin n0++; cd0 = cd0 + 1; end
            if (bus.req_ready[1]) begin n1++; cd1 = cd1 + 1; end
            bus.req_data = {cd1, cd0};
            exp_g  = ~exp_g;
            grants++;
         end
      end
      chk("cont grants", 64'(grants), 64'd20);
      chk("cont n0", 64'(n0), 64'd10);
      chk("cont n1", 64'(n1), 64'd10);
      bus.req_valid = 2'b00;
      step();
      chk("cont drain", 64'(bus.mem_valid), 64'd0);
`ifdef REG_WR_ARB_STATS_EN
      chk("cont grant_cnt", 64'(grant_cnt), {32'd0, 16'd10, 16'd10});
`endif

      // Reset mid-ISSUE drops the write and restarts rotation at requester 0.
      drive(2'b01, 32'h55555555, 8'h55, 32'h66666666, 8'h66, 1'b0);
      step();
      chk("mid accept", {bus.req_ready, bus.mem_valid}, {2'b01, 1'b1});
      bus.req_valid = 2'b00;
      rst = 1'b1;
      step();
      chk("mid reset", {bus.req_ready, bus.mem_valid, bus.busy, bus.grant_id, bus.mem_addr},
          {2'b00, 1'b0, 1'b0, 1'b0, 8'h00});
`ifdef REG_WR_ARB_STATS_EN
      chk("mid grant_cnt", 64'(grant_cnt), 64'd0);
`endif
      rst = 1'b0;
      drive(2'b11, 32'h77777777, 8'h77, 32'h88888888, 8'h88, 1'b1);
      step();
      chk("post reset grant", {bus.req_ready, bus.grant_id, bus.mem_addr}, {2'b01, 1'b0, 8'h77});
      bus.req_valid = 2'b00;
      step();
      chk("post reset done", 64'(bus.mem_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
